// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
// Contents: bus/lane geometry, the access FSM state type, RISC-V load/store
// funct3 encodings, and a helper that decides whether a request carries a
// funct3 the unit will act on.
package dmem_access_unit_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Stores only accept the signed-size encodings; loads also accept BU/HU.
  function automatic logic is_legal_f3(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_store)
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    return ok;
  endfunction

endpackage

// File: rtl/dmem_access_unit_lane_align.sv
// Combinational byte-lane steering for one access.
// Ports:
//   funct3     in  3  : access size (low two bits select B/H/W)
//   off        in  2  : byte offset within the word (addr[1:0])
//   store_data in  32 : store value, data in the low bits
//   be         out 4  : byte-lane enables
//   wdata      out 32 : store data moved onto its lanes
//   misaligned out 1  : size/offset combination crosses a natural boundary
// Legality of funct3 for the request type is decided by the caller; this
// block only looks at the size field.
module dmem_access_unit_lane_align
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] store_data,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata,
  output logic              misaligned
);

  always_comb begin
    be         = '0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: be = 4'b0001 << off;
      2'b01: begin
        be         = 4'b0011 << off;
        misaligned = off[0];
      end
      2'b10: begin
        be         = 4'b1111;
        misaligned = (off != 2'b00);
      end
      default: begin
        be         = '0;
        misaligned = 1'b0;
      end
    endcase
  end

  // Upper bytes shifted past bit 31 are simply dropped.
  assign wdata = store_data << {off, 3'b000};

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage access controller: converts a load/store request into a
// word-aligned, byte-enabled single-port bus transaction and stalls the
// pipeline until it completes. Read data is returned right-aligned.
// Ports:
//   clk, rst (sync, active-high)
//   mem_read, mem_write, funct3, addr, store_data : request from MEM stage
//   stall      : holds IF..MEM while the access is in flight
//   misaligned : combinational misalignment flag (no bus activity)
//   load_word  : registered read word, shifted right by 8*addr[1:0]
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : registered bus request
//   bus_gnt, bus_rvalid, bus_rdata           : bus responses
module dmem_access_unit
  import dmem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              misaligned,
  output logic [31:0]       load_word,
  output logic              bus_req,
  output logic              bus_we,
  output logic [31:0]       bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  state_t      r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_load_word;
  logic [1:0]  r_off;

  logic        w_legal;
  logic        w_mis_raw;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rshift;

  dmem_access_unit_lane_align u_lane_align (
    .funct3     (funct3),
    .off        (addr[1:0]),
    .store_data (store_data),
    .be         (w_be),
    .wdata      (w_wdata),
    .misaligned (w_mis_raw)
  );

  // mem_write takes priority, so legality is judged against the store table
  // whenever it is high.
  assign w_legal = (mem_write || mem_read) && is_legal_f3(mem_write, funct3);

  assign misaligned = w_legal && w_mis_raw;
  assign w_start    = (r_state == ST_IDLE) && w_legal && !w_mis_raw;
  assign stall      = w_start || (r_state == ST_REQ) || (r_state == ST_WAIT);

  // Offset is taken from the registered copy so the shift matches the
  // access that was issued, not whatever is on addr now.
  assign w_rshift = bus_rdata >> {r_off, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_load_word <= '0;
      r_off       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_bus_we    <= mem_write;
            r_off       <= addr[1:0];
            r_bus_req   <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            if (r_bus_we) begin
              r_state <= ST_DONE;
            end else if (bus_rvalid) begin
              r_load_word <= w_rshift;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus_rvalid) begin
            r_load_word <= w_rshift;
            r_state     <= ST_DONE;
          end
        end
        // Inputs still show the finished instruction here, so they are ignored.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;
  assign load_word = r_load_word;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        misaligned;
  logic [31:0] load_word;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int tests;
  int fails;

  // Snapshot of the bus request taken during the first REQ cycle.
  logic        s_seen;
  logic        s_we;
  logic [31:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;

  dmem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .misaligned (misaligned),
    .load_word  (load_word),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered at posedge+1 with the FSM in IDLE; returns at posedge+1 back in
  // IDLE. Grants after gdel extra REQ cycles; rvalid follows grant by rdel
  // cycles (0 = same cycle). Counts cycles with stall high.
  task automatic do_access(input logic mr, input logic mw, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int gdel, input int rdel, input logic [31:0] rd,
                           output int nstall, output logic timed_out);
    int req_cycles;
    int gnt_cycle;
    logic ended;
    nstall = 0; req_cycles = 0; gnt_cycle = -1; ended = 1'b0;
    s_seen = 1'b0;
    mem_read = mr; mem_write = mw; funct3 = f3; addr = a; store_data = sd;
    bus_rdata = rd;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!stall) begin
        ended = 1'b1;
        break;
      end
      nstall++;
      if (bus_req) begin
        req_cycles++;
        if (!s_seen) begin
          s_seen = 1'b1; s_we = bus_we; s_addr = bus_addr;
          s_be = bus_be; s_wdata = bus_wdata;
        end
        if (req_cycles > gdel) begin
          bus_gnt = 1'b1;
          gnt_cycle = c;
          if (rdel == 0) bus_rvalid = 1'b1;
        end
      end
      if (gnt_cycle >= 0 && rdel > 0 && c == gnt_cycle + rdel) bus_rvalid = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
    end
    timed_out = !ended;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus_req, bus_we, stall, misaligned} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got %b want 0000", {bus_req, bus_we, stall, misaligned});
    end
    tests++;
    if (bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0 || load_word !== 32'h0) begin
      fails++; $display("FAIL reset_data addr=%h be=%h wdata=%h lw=%h want all 0",
                        bus_addr, bus_be, bus_wdata, load_word);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sw_aligned();
    int n; logic to;
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, n, to);
    tests++;
    if (to || n != 2) begin fails++; $display("FAIL sw_stall got %0d (to=%0b) want 2", n, to); end
    tests++;
    if (!s_seen || s_we !== 1'b1 || s_be !== 4'b1111 || s_addr !== 32'h100 || s_wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL sw_bus we=%b be=%b addr=%h wdata=%h want 1 1111 00000100 deadbeef",
                        s_we, s_be, s_addr, s_wdata);
    end
    tests++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL sw_idle req=%b stall=%b want 0 0", bus_req, stall);
    end
  endtask

  task automatic test_sb_offset3();
    int n; logic to;
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0, n, to);
    tests++;
    if (to || s_be !== 4'b1000 || s_wdata !== 32'hA5000000 || s_addr !== 32'h100) begin
      fails++; $display("FAIL sb_off3 be=%b wdata=%h addr=%h want 1000 a5000000 00000100",
                        s_be, s_wdata, s_addr);
    end
  endtask

  task automatic test_sh_offset2();
    int n; logic to;
    do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h1234BEEF, 1, 0, 32'h0, n, to);
    tests++;
    if (to || n != 3 || s_be !== 4'b1100 || s_wdata !== 32'hBEEF0000 || s_addr !== 32'h10) begin
      fails++; $display("FAIL sh_off2 n=%0d be=%b wdata=%h addr=%h want 3 1100 beef0000 00000010",
                        n, s_be, s_wdata, s_addr);
    end
  endtask

  task automatic test_lhu_delays();
    int n; logic to;
    do_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 2, 1, 32'h80011234, n, to);
    tests++;
    if (to || n != 5) begin fails++; $display("FAIL lhu_stall got %0d (to=%0b) want 5", n, to); end
    tests++;
    if (load_word !== 32'h00008001) begin
      fails++; $display("FAIL lhu_data got %h want 00008001", load_word);
    end
    tests++;
    if (s_we !== 1'b0 || s_be !== 4'b1100 || s_addr !== 32'h200) begin
      fails++; $display("FAIL lhu_bus we=%b be=%b addr=%h want 0 1100 00000200", s_we, s_be, s_addr);
    end
  endtask

  task automatic test_load_latency();
    int n; logic to;
    do_access(1'b1, 1'b0, 3'b000, 32'h401, 32'h0, 0, 1, 32'h11223344, n, to);
    tests++;
    if (to || n != 3 || load_word !== 32'h00112233 || s_be !== 4'b0010) begin
      fails++; $display("FAIL lb_off1 n=%0d lw=%h be=%b want 3 00112233 0010", n, load_word, s_be);
    end
    do_access(1'b1, 1'b0, 3'b010, 32'h408, 32'h0, 0, 0, 32'hCAFEF00D, n, to);
    tests++;
    if (to || n != 2 || load_word !== 32'hCAFEF00D) begin
      fails++; $display("FAIL lw_same n=%0d lw=%h want 2 cafef00d", n, load_word);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic to;
    do_access(1'b1, 1'b0, 3'b100, 32'h503, 32'h0, 0, 0, 32'h9A000000, n, to);
    tests++;
    if (to || n != 2 || load_word !== 32'h0000009A) begin
      fails++; $display("FAIL b2b_first n=%0d lw=%h want 2 0000009a", n, load_word);
    end
    do_access(1'b1, 1'b0, 3'b001, 32'h506, 32'h0, 0, 0, 32'h7F010000, n, to);
    tests++;
    if (to || n != 2 || load_word !== 32'h00007F01 || s_addr !== 32'h504) begin
      fails++; $display("FAIL b2b_second n=%0d lw=%h addr=%h want 2 00007f01 00000504",
                        n, load_word, s_addr);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] lw_before;
    logic        req_seen;
    lw_before = load_word;
    req_seen = 1'b0;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h301;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    tests++;
    if (misaligned !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL lw_mis mis=%b stall=%b want 1 0", misaligned, stall);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus_req) req_seen = 1'b1;
    end
    tests++;
    if (req_seen || load_word !== lw_before) begin
      fails++; $display("FAIL lw_mis_quiet req_seen=%b lw=%h want 0 %h", req_seen, load_word, lw_before);
    end
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b001; addr = 32'h305;
    @(negedge clk);
    tests++;
    if (misaligned !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL sh_mis mis=%b stall=%b want 1 0", misaligned, stall);
    end
    mem_write = 1'b0; mem_read = 1'b1; funct3 = 3'b001; addr = 32'h306;
    #1;
    tests++;
    if (misaligned !== 1'b0 || stall !== 1'b1) begin
      fails++; $display("FAIL lh_ok mis=%b stall=%b want 0 1", misaligned, stall);
    end
    mem_read = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h600; bus_rdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    tests++;
    if (stall !== 1'b1 || bus_req !== 1'b0) begin
      fails++; $display("FAIL wait_state stall=%b req=%b want 1 0", stall, bus_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || load_word !== 32'h0) begin
      fails++; $display("FAIL rst_wait stall=%b req=%b lw=%h want 0 0 00000000", stall, bus_req, load_word);
    end
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (load_word !== 32'h0 || stall !== 1'b0) begin
      fails++; $display("FAIL rst_late_rvalid lw=%h stall=%b want 00000000 0", load_word, stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rw_priority();
    int n; logic to;
    do_access(1'b1, 1'b1, 3'b010, 32'h700, 32'h12345678, 0, 0, 32'hFFFFFFFF, n, to);
    tests++;
    if (to || n != 2 || s_we !== 1'b1 || s_wdata !== 32'h12345678) begin
      fails++; $display("FAIL rw_prio n=%0d we=%b wdata=%h want 2 1 12345678", n, s_we, s_wdata);
    end
    mem_read = 1'b1; funct3 = 3'b011; addr = 32'h701;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || misaligned !== 1'b0) begin
      fails++; $display("FAIL f3_011 stall=%b mis=%b want 0 0", stall, misaligned);
    end
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b101; addr = 32'h703;
    #1;
    tests++;
    if (stall !== 1'b0 || misaligned !== 1'b0) begin
      fails++; $display("FAIL store_f3_101 stall=%b mis=%b want 0 0", stall, misaligned);
    end
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b0) begin fails++; $display("FAIL illegal_no_req req=%b want 0", bus_req); end
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_sw_aligned();
    test_sb_offset3();
    test_sh_offset2();
    test_lhu_delays();
    test_load_latency();
    test_back_to_back();
    test_misaligned();
    test_rw_priority();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage access controller that sits directly upstream of the load formatter. It turns a MemRead/MemWrite request into a word-aligned, byte-enabled transaction on a single-port data-memory bus, and stalls the pipeline until the bus completes. It delivers the read word right-aligned to the addressed byte, so the formatter only sign- or zero-extends the low bits. Misaligned accesses are detected here and never reach the bus.

## Interface
Parameters:
- none (32-bit datapath, 4 byte lanes, fixed)

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: load request from the MEM pipeline register.
- `mem_write` in 1: store request; wins if `mem_read` is also high.
- `funct3` in 3: access size/type. 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
- `addr` in 32: byte address (ALU result).
- `store_data` in 32: rs2 value, data in the low bits.
- `stall` out 1: freezes the IF–MEM pipeline registers while high.
- `misaligned` out 1: combinational flag for a misaligned access.
- `load_word` out 32: registered read data, shifted right by `8*addr[1:0]` with zero fill.
- `bus_req` out 1: bus request; held high until granted.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte-lane enables.
- `bus_wdata` out 32: lane-aligned store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: `bus_rdata` valid this cycle.
- `bus_rdata` in 32: read word.

## Operation
- **Valid access**: (`mem_read` | `mem_write`) with a legal `funct3`. For stores, only funct3 000/001/010 are legal. Any other `funct3` is treated as no access: no stall and no flag.
- **Misaligned**:
  - H/HU/SH with `addr[0]` = 1.
  - W/SW with `addr[1:0]` ≠ 0.
  - Response: `misaligned` = 1, no bus activity, `stall` = 0, `load_word` unchanged.
- **Byte enables** (`off` = `addr[1:0]`):
  - B/BU/SB: `4'b0001 << off`.
  - H/HU/SH: `4'b0011 << off`.
  - W/SW: `4'b1111`.
  - Loads also drive `bus_be`.
- **Write data**: `bus_wdata` = `store_data << 8*off`. Bits shifted out are discarded.
- **FSM states**: IDLE, REQ, WAIT, DONE.
  - IDLE: on a valid aligned access, register `bus_addr`/`bus_be`/`bus_wdata`/`bus_we` and go to REQ.
  - REQ: `bus_req` = 1. On `bus_gnt`:
    - write → DONE.
    - read with `bus_rvalid` in the same cycle → capture data, go to DONE.
    - otherwise read → WAIT.
  - WAIT: on `bus_rvalid`, set `load_word` ← `bus_rdata >> 8*off`, go to DONE.
  - DONE: `stall` = 0 for exactly one cycle; pipeline advances; go to IDLE. Request inputs are ignored in DONE because they still belong to the completed instruction.
- **stall** = (IDLE & valid aligned access) | REQ | WAIT. This is combinational, so stall rises in the same cycle the access appears.
- `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are registered outputs. They hold their values outside REQ, and `bus_req` is 0 outside REQ.
- `bus_rvalid` outside REQ/WAIT is ignored. `bus_gnt` outside REQ is ignored.

## Timing
- **Reset values**:
  - state IDLE.
  - `bus_req` 0, `bus_we` 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `load_word` all 0.
  - `stall` and `misaligned` follow the inputs combinationally.
- **Store, grant on first REQ cycle**: stall high for 2 cycles (IDLE, REQ); DONE in cycle 3.
- **Load, grant and rvalid one cycle apart**: stall high for 3 cycles; `load_word` is valid from the DONE cycle onward. If grant and rvalid coincide, stall is 2 cycles.
- **Unbounded wait**: no timeout; the unit stalls as long as `bus_gnt`/`bus_rvalid` are withheld.
- **Back-to-back accesses**: the next access is recognised in the IDLE cycle after DONE. Throughput is at best one access per 3 cycles.
- **Reset mid-operation** (REQ or WAIT): return to IDLE the next cycle, `bus_req` drops, and any late `bus_rvalid` is ignored.

## Structure
- Shared package:
  - FSM state enum.
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - lane width constants.
- Sub-module `lane_align`: combinational. Inputs `funct3`, `addr[1:0]`, `store_data`. Outputs `bus_be`, shifted write data and `misaligned`.
- The FSM and registers live in the top module.

## Test plan
- **SW aligned**: `addr`=0x100, data=0xDEADBEEF, gnt on first REQ cycle → `bus_be`=1111, `bus_addr`=0x100, `bus_wdata`=0xDEADBEEF, stall exactly 2 cycles.
- **SB offset 3**: `addr`=0x103, data=0x000000A5 → `bus_be`=1000, `bus_wdata`=0xA5000000, `bus_addr`=0x100.
- **LHU offset 2 with delays**: `addr`=0x202, `bus_rdata`=0x8001xxxx, gnt delayed 2 cycles, rvalid delayed 1 more → `load_word`=0x00008001, stall held throughout (5 cycles).
- **LW misaligned**: `addr`=0x301 → `misaligned`=1, `bus_req` never rises, stall 0.
- **Reset in WAIT**: `rst` asserted while in WAIT, then `bus_rvalid` arrives → IDLE, `bus_req`=0, `load_word`=0 and unchanged.
- **Simultaneous read/write**: `mem_read`=`mem_write`=1, funct3=010 → `bus_we`=1 (write wins). Then `funct3`=011 with `mem_read`=1 → no access, stall 0.
